chunked_seq_adder: RTL and testbench
====================================

# chunked_seq_adder

Parametrised multi-cycle adder: a WIDTH-bit ripple addition done CHUNK bits per clock over WIDTH/CHUNK cycles, with valid/ready handshakes on input and output. It is the registered, width-generic successor to the 8-bit combinational adder. The multiplier datapaths use it for wide partial-product accumulation where a single-cycle WIDTH-bit carry chain would not meet timing. It also reports signed overflow, which the combinational adder does not.

## Interface
- `WIDTH`, default 8: operand and sum width. Must be ≥2 and an integer multiple of CHUNK.
- `CHUNK`, default 2: bits added per cycle. N = WIDTH/CHUNK is the number of compute cycles.
- `clk` input, 1 bit: the only clock; all state changes on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: operands `a`, `b`, `cin` (and `sub` when configured) are valid.
- `in_ready` output, 1 bit: the block can accept operands.
- `a` input, WIDTH bits: addend.
- `b` input, WIDTH bits: addend (subtrahend when `sub`=1).
- `cin` input, 1 bit: carry-in.
- `sub` input, 1 bit: present only with ADDER_SUB_EN. 1 = subtract.
- `out_valid` output, 1 bit: `s`, `cout` and `ovf` hold a complete result.
- `out_ready` input, 1 bit: the consumer takes the result.
- `s` output, WIDTH bits: sum, equal to (a+b+cin) mod 2^WIDTH.
- `cout` output, 1 bit: carry out of bit WIDTH-1.
- `ovf` output, 1 bit: two's-complement signed overflow, defined as carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `a`, `b` and the effective carry; clear chunk index k to 0; go to RUN.
- RUN:
  - Each edge adds bits [k*CHUNK +: CHUNK] of A and B plus the carry register.
  - Writes that slice of `s`, stores the chunk carry-out in the carry register, and increments k.
  - On the edge that processes chunk N-1: set `cout` from the final carry and `ovf` from the MSB carries; go to DONE.
- DONE:
  - `out_valid`=1; `s`, `cout`, `ovf` are stable.
  - On `out_ready`=1, go to IDLE.
- `in_ready`=0 in RUN and DONE. There is no overlap between operations. `in_valid` is ignored outside IDLE.
- `s` shows partial results during RUN. `s`, `cout` and `ovf` are meaningful only while `out_valid`=1. They hold their values after DONE until the next operation writes them.
- Reset values: `in_ready`=0 while `rst`=1 and 1 in the first cycle after reset; `out_valid`=0, `s`=0, `cout`=0, `ovf`=0, k=0, carry register=0.
- `rst` asserted in any state, including mid-RUN or in DONE with `out_ready` low:
  - The in-flight operation is discarded and never reported.
  - All registers return to their reset values on that edge.
- Widths: internal chunk sum is CHUNK+1 bits. k is clog2(N) bits wide, or 1 bit when N=1.
- When CHUNK=WIDTH (N=1): one RUN cycle, and the output is still registered.

## Timing
- Accept edge E0 → RUN edges E1..EN → `out_valid` high in the cycle after EN. Latency is N clock edges from accept to valid output.
- Output handshake completes on the first edge with `out_valid`&&`out_ready`. `in_ready` rises in the following cycle.
- With `in_valid` and `out_ready` held high, the block accepts one operation every N+2 cycles. With WIDTH=8, CHUNK=2 that is 6 cycles.
- `out_ready` low in DONE stalls indefinitely; outputs stay stable.
- No combinational paths from inputs to outputs.

## Configuration
- `ADDER_SUB_EN` defined:
  - The `sub` port exists.
  - `sub`=1 latches ~b and forces carry-in to 1, ignoring `cin`. Result: `s`=a-b mod 2^WIDTH, `cout`=1 meaning no borrow, `ovf` = signed subtraction overflow.
  - `sub`=0 behaves as plain add.
- `ADDER_SUB_EN` undefined: no `sub` port; addition only.

## Test plan
All scenarios use WIDTH=8, CHUNK=2 unless stated.
1. Reset, then a=0x00, b=0x01, cin=0 → `out_valid` after 4 edges; s=0x01, cout=0, ovf=0.
2. a=0x02, b=0x03, cin=1 → s=0x06, cout=0, ovf=0. Then a=0xFF, b=0xFF, cin=0 → s=0xFE, cout=1, ovf=0.
3. a=0x40, b=0x40, cin=0 → s=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 → s=0x00, cout=1, ovf=1.
4. Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → s, cout, ovf and `out_valid` stable, `in_ready`=0. Release → `in_ready`=1 the next cycle.
5. Assert `rst` on edge E2 of a 0xA4+0x42 operation → `out_valid` never rises for it; outputs are 0. A following 0x4A+0x49 returns s=0x93, ovf=1.
6. With ADDER_SUB_EN: a=0x05, b=0x07, sub=1 → s=0xFE, cout=0. a=0x07, b=0x05 → s=0x02, cout=1. With WIDTH=16, CHUNK=16: 0xFFFF+0x0001 → s=0x0000, cout=1 after 1 edge.

Source files
------------

// File: rtl/chunked_seq_adder_if.sv
// rtl/chunked_seq_adder_if.sv - operand/result handshake bundle for chunked_seq_adder (sub port present only with ADDER_SUB_EN)
interface chunked_seq_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    // Producer/consumer side: supplies operands and takes results.
    modport master (
`ifdef ADDER_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    // Adder side.
    modport slave (
`ifdef ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - WIDTH-bit adder computed CHUNK bits per clock with valid/ready handshakes; ADDER_SUB_EN adds subtraction
module chunked_seq_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic               clk,
    input  logic               rst,
    chunked_seq_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic [KW-1:0]    k_r;

    logic             accept;
    logic             last_chunk;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   chunk_sum;
    logic             ovf_final;

    // Subtraction is a - b = a + ~b + 1, so it reuses the add datapath.
    always_comb begin
`ifdef ADDER_SUB_EN
        b_eff   = bus.sub ? ~bus.b : bus.b;
        cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
        b_eff   = bus.b;
        cin_eff = bus.cin;
`endif
    end

    // One CHUNK-wide ripple slice; signed overflow compares carry into and out of the MSB.
    always_comb begin
        a_slice    = a_r[k_r*CHUNK +: CHUNK];
        b_slice    = b_r[k_r*CHUNK +: CHUNK];
        chunk_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_r};
        ovf_final  = chunk_sum[CHUNK] ^ (a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ chunk_sum[CHUNK-1]);
        last_chunk = (k_r == KW'(N - 1));
    end

    // Next-state logic; accept only once in_ready is actually shown to the producer.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, per-chunk accumulation and registered in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            s_r        <= '0;
            carry_r    <= 1'b0;
            cout_r     <= 1'b0;
            ovf_r      <= 1'b0;
            k_r        <= '0;
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= (state_next == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r     <= bus.a;
                        b_r     <= b_eff;
                        carry_r <= cin_eff;
                        k_r     <= '0;
                    end
                end
                RUN: begin
                    s_r[k_r*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry_r                 <= chunk_sum[CHUNK];
                    k_r                     <= k_r + KW'(1);
                    if (last_chunk) begin
                        cout_r <= chunk_sum[CHUNK];
                        ovf_r  <= ovf_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = (state == DONE);
    assign bus.s         = s_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb/tb_chunked_seq_adder.sv - directed self-checking bench for chunked_seq_adder (8/2 and 16/16 instances)
module tb_chunked_seq_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    chunked_seq_adder_if #(.WIDTH(8))  bus8 ();
    chunked_seq_adder_if #(.WIDTH(16)) bus16 ();

    chunked_seq_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) u_wide (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one operation on the 8-bit instance from a negedge, check latency,
    // hold out_ready low for 'stall' cycles, then complete the handshake.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tcin, input logic tsub, input int stall,
                          input logic [7:0] es, input logic ecout, input logic eovf);
        int n;
        logic stable;
        n = 0;
        while (!bus8.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
        bus8.a        = ta;
        bus8.b        = tb_v;
        bus8.cin      = tcin;
`ifdef ADDER_SUB_EN
        bus8.sub      = tsub;
`endif
        bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        n = 0;
        while (!bus8.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        check({tag, "_s"}, 32'(bus8.s), 32'(es));
        check({tag, "_cout"}, 32'(bus8.cout), 32'(ecout));
        check({tag, "_ovf"}, 32'(bus8.ovf), 32'(eovf));
        if (stall > 0) begin
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 || bus8.s !== es ||
                    bus8.cout !== ecout || bus8.ovf !== eovf) begin
                    stable = 1'b0;
                end
            end
            check({tag, "_stall_stable"}, 32'(stable), 32'd1);
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(bus8.out_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(bus8.in_ready), 32'd1);
    endtask

    initial begin
        int   n;
        logic seen;
        bus8.in_valid   = 1'b0;
        bus8.a          = '0;
        bus8.b          = '0;
        bus8.cin        = 1'b0;
        bus8.out_ready  = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.cin       = 1'b0;
        bus16.out_ready = 1'b0;
`ifdef ADDER_SUB_EN
        bus8.sub        = 1'b0;
        bus16.sub       = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus8.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_s", 32'(bus8.s), 32'd0);
        check("rst_cout", 32'(bus8.cout), 32'd0);
        check("rst_ovf", 32'(bus8.ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);

        // Plain additions
        run_op("t1", 8'h00, 8'h01, 1'b0, 1'b0, 0, 8'h01, 1'b0, 1'b0);
        run_op("t2a", 8'h02, 8'h03, 1'b1, 1'b0, 0, 8'h06, 1'b0, 1'b0);
        run_op("t2b", 8'hFF, 8'hFF, 1'b0, 1'b0, 0, 8'hFE, 1'b1, 1'b0);
        run_op("t3a", 8'h40, 8'h40, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1);
        run_op("t3b", 8'h80, 8'h80, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b1);
        run_op("carry_chain", 8'hF0, 8'h0F, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0);

        // Backpressure
        run_op("t4", 8'h7F, 8'h01, 1'b0, 1'b0, 5, 8'h80, 1'b0, 1'b1);

        // Reset on the second RUN edge discards the operation
        bus8.a        = 8'hA4;
        bus8.b        = 8'h42;
        bus8.cin      = 1'b0;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_in_ready", 32'(bus8.in_ready), 32'd0);
        check("t5_rst_s", 32'(bus8.s), 32'd0);
        check("t5_rst_cout", 32'(bus8.cout), 32'd0);
        check("t5_rst_ovf", 32'(bus8.ovf), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus8.out_valid) seen = 1'b1;
        end
        check("t5_no_valid", 32'(seen), 32'd0);
        run_op("t5b", 8'h4A, 8'h49, 1'b0, 1'b0, 0, 8'h93, 1'b0, 1'b1);

`ifdef ADDER_SUB_EN
        run_op("t6_sub_a", 8'h05, 8'h07, 1'b0, 1'b1, 0, 8'hFE, 1'b0, 1'b0);
        run_op("t6_sub_b", 8'h07, 8'h05, 1'b0, 1'b1, 0, 8'h02, 1'b1, 1'b0);
        run_op("t6_add", 8'h07, 8'h05, 1'b1, 1'b0, 0, 8'h0D, 1'b0, 1'b0);
`endif

        // Single-chunk 16-bit instance
        check("wide_in_ready", 32'(bus16.in_ready), 32'd1);
        bus16.a        = 16'hFFFF;
        bus16.b        = 16'h0001;
        bus16.cin      = 1'b0;
        bus16.in_valid = 1'b1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        n = 0;
        while (!bus16.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wide_latency", 32'(n), 32'd1);
        check("wide_s", 32'(bus16.s), 32'h0000);
        check("wide_cout", 32'(bus16.cout), 32'd1);
        check("wide_ovf", 32'(bus16.ovf), 32'd0);
        bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.out_ready = 1'b0;
        check("wide_done_ready", 32'(bus16.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
